mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM-stage load/store engine. It is the consumer of the EX stage's memory request (mem_ce, address, store data, op).
- Executes each request over a byte-wide, single-port synchronous RAM.
  - Loads: assembles bytes little-endian, then sign- or zero-extends to 32 bits.
  - Stores: serialises bytes onto the RAM port.
- Stalls the pipeline for the whole transaction. Non-memory instructions pass through with no stall.

Parameters:
ADDR_W, 17, RAM byte-address width; addr_i truncated to ADDR_W bits.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-low (rst==0 resets on clk edge)
req_i  input  1  memory request valid (EX mem_ce)
we_i  input  1  1=store, 0=load
size_i  input  2  0=byte, 1=half, 2=word; 3 treated as word
unsigned_i  input  1  load zero-extend (LBU/LHU); ignored for stores
addr_i  input  32  effective byte address
sdata_i  input  32  store data; low bytes used
alu_wdata_i  input  32  EX result for non-memory instrs
wd_i  input  5  destination register
wreg_i  input  1  register write enable
wdata_o  output  32  writeback data
wd_o  output  5  destination register
wreg_o  output  1  writeback enable
stallreq_o  output  1  pipeline stall request
mem_a_o  output  ADDR_W  RAM byte address
mem_dout_o  output  8  RAM write data
mem_wr_o  output  1  RAM write strobe
mem_din_i  input  8  RAM read data; valid the cycle after its address is presented

Behaviour:
- Byte count N is 1, 2 or 4, taken from size_i.
- Byte k address = (addr_i + k) mod 2^ADDR_W. Address wraps at the top of the RAM.
- Byte order: little-endian, byte k = bits [8k+7:8k].
- Request capture: on the first cycle of req_i in IDLE, latch we, N, unsigned, addr, sdata, wd and wreg. Later changes on the inputs are ignored until DONE.
- States: IDLE, RD, RLAST, WR, DONE. Counter cnt is 2 bits.
- IDLE
  - req_i=0: no stall. wdata_o=alu_wdata_i, wd_o=wd_i, wreg_o=wreg_i (combinational pass-through). mem_wr_o=0.
  - req_i=1: stallreq_o=1 (combinational). Next state is RD if load, WR if store. cnt<=0.
- RD
  - Drive mem_a_o = base+cnt, mem_wr_o=0.
  - If cnt>=1, capture mem_din_i into byte cnt-1.
  - cnt==N-1: go to RLAST. Otherwise cnt++.
- RLAST
  - mem_wr_o=0; capture mem_din_i into byte N-1.
  - Go to DONE.
- WR
  - Drive mem_a_o = base+cnt, mem_dout_o = store byte cnt, mem_wr_o=1.
  - cnt==N-1: go to DONE. Otherwise cnt++.
- DONE
  - stallreq_o=0.
  - wdata_o is the registered result:
    - load: extended data;
    - store: 0, with wreg_o forced 0.
  - wd_o/wreg_o come from latched values.
  - Next state is always IDLE. A new req_i is evaluated only in IDLE, so the request held during DONE is never re-issued.
- Extension:
  - byte load: bit 7 replicated, or zeros if unsigned;
  - half load: bit 15 replicated, or zeros if unsigned;
  - word load: unchanged.
- Latency (stall cycles, counted from the first req_i cycle):
  - load: N+2 (byte 3, half 4, word 6);
  - store: N+1 (byte 2, half 3, word 5).
  - DONE is always 1 cycle.
- stallreq_o=1 in IDLE-with-req, RD, RLAST and WR.
- mem_wr_o=1 only in WR. mem_a_o holds its last value when not in RD or WR.
- Reset (rst==0 at an edge):
  - state<=IDLE, cnt<=0, result<=0.
  - Registered outputs go to 0: mem_a_o, mem_dout_o, mem_wr_o.
  - Because IDLE outputs are combinational, stallreq_o/wdata_o/wd_o/wreg_o follow req_i/alu_wdata_i/wd_i/wreg_i in IDLE.
  - Reset mid-store abandons the remaining bytes. Bytes already written stay written.
  - mem_wr_o is 0 from the first cycle after the reset edge.
  - No retry after reset.

Test Plan:
- LW addr 0x100, RAM[0x100..0x103]=78,56,34,12 -> mem_a 0x100..0x103 on 4 consecutive cycles; 6 stall cycles; DONE wdata_o=0x12345678, wreg_o=1.
- LB at 0x80 with RAM=0x80 -> 0xFFFFFF80. LBU same address -> 0x00000080. LH with bytes 0xFE,0x7F -> 0x00007FFE. Each byte load stalls 3 cycles.
- SH sdata 0x1234ABCD at 0x1FFFF (ADDR_W=17) -> cycle1 a=0x1FFFF d=0xCD wr=1; cycle2 a=0x00000 d=0xAB wr=1; DONE wreg_o=0; 3 stall cycles.
- SW 0xDEADBEEF at 0x10, rst=0 asserted after the second write cycle -> only 0xEF@0x10 and 0xBE@0x11 written; mem_wr_o=0 thereafter; IDLE; no further writes.
- Non-memory stream (req_i=0, alu_wdata_i=0x55) -> no stall; wdata_o=0x55 in the same cycle. Back-to-back LW then SB, each held until its DONE -> each executes exactly once, with correct latencies 6 and 2.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store engine: serialises a 1/2/4-byte access over a byte-wide sync RAM.
// Latency: load N+2 stall cycles, store N+1, then one DONE cycle with registered result.
// Backpressure: stallreq_o holds the pipeline for the whole access; non-memory ops pass through.
module mem_access_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       sdata_i,
    input  logic [31:0]       alu_wdata_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    output logic [31:0]       wdata_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic              stallreq_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [7:0]        mem_dout_o,
    output logic              mem_wr_o,
    input  logic [7:0]        mem_din_i
);

    typedef enum logic [2:0] {IDLE, RD, RLAST, WR, DONE} state_t;

    state_t            state;
    logic [1:0]        cnt;
    logic [1:0]        last_q;     // index of the final byte (N-1)
    logic              we_q;
    logic              uns_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       sdata_q;
    logic [4:0]        wd_q;
    logic              wreg_q;
    logic [31:0]       buf_q;      // load bytes gathered so far
    logic [31:0]       result_q;

    logic [1:0]        req_last;
    logic [1:0]        cnt_inc;
    logic [1:0]        cnt_dec;
    logic [ADDR_W-1:0] a_next;
    logic [31:0]       ld_word;

    // Address bits above the RAM size are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[31:ADDR_W];

    assign req_last = (size_i == 2'd0) ? 2'd0 : (size_i == 2'd1) ? 2'd1 : 2'd3;
    assign cnt_inc  = cnt + 2'd1;
    assign cnt_dec  = cnt - 2'd1;
    assign a_next   = base_q + {{(ADDR_W-2){1'b0}}, cnt_inc};

    function automatic logic [31:0] extend(input logic [31:0] w,
                                           input logic [1:0]  last,
                                           input logic        uns);
        case (last)
            2'd0:    extend = {{24{~uns & w[7]}},  w[7:0]};
            2'd1:    extend = {{16{~uns & w[15]}}, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    // Final load word: gathered bytes plus the last byte arriving from the RAM now.
    always_comb begin
        ld_word = buf_q;
        case (last_q)
            2'd0:    ld_word[7:0]   = mem_din_i;
            2'd1:    ld_word[15:8]  = mem_din_i;
            default: ld_word[31:24] = mem_din_i;
        endcase
    end

    // Transaction FSM; RAM port signals are registered one cycle ahead of their state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            last_q     <= 2'd0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            base_q     <= '0;
            sdata_q    <= 32'd0;
            wd_q       <= 5'd0;
            wreg_q     <= 1'b0;
            buf_q      <= 32'd0;
            result_q   <= 32'd0;
            mem_a_o    <= '0;
            mem_dout_o <= 8'd0;
            mem_wr_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        cnt     <= 2'd0;
                        last_q  <= req_last;
                        we_q    <= we_i;
                        uns_q   <= unsigned_i;
                        base_q  <= addr_i[ADDR_W-1:0];
                        sdata_q <= sdata_i;
                        wd_q    <= wd_i;
                        wreg_q  <= wreg_i;
                        buf_q   <= 32'd0;
                        mem_a_o <= addr_i[ADDR_W-1:0];
                        if (we_i) begin
                            state      <= WR;
                            mem_dout_o <= sdata_i[7:0];
                            mem_wr_o   <= 1'b1;
                        end else begin
                            state    <= RD;
                            mem_wr_o <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (cnt != 2'd0)
                        buf_q[{cnt_dec, 3'b000} +: 8] <= mem_din_i;
                    if (cnt == last_q) begin
                        state <= RLAST;
                    end else begin
                        cnt     <= cnt_inc;
                        mem_a_o <= a_next;
                    end
                end
                RLAST: begin
                    result_q <= extend(ld_word, last_q, uns_q);
                    state    <= DONE;
                end
                WR: begin
                    if (cnt == last_q) begin
                        mem_wr_o <= 1'b0;
                        result_q <= 32'd0;
                        state    <= DONE;
                    end else begin
                        cnt        <= cnt_inc;
                        mem_a_o    <= a_next;
                        mem_dout_o <= sdata_q[{cnt_inc, 3'b000} +: 8];
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    mem_wr_o <= 1'b0;
                end
            endcase
        end
    end

    // Writeback/stall outputs: pass-through in IDLE, latched values otherwise.
    always_comb begin
        stallreq_o = 1'b0;
        wdata_o    = result_q;
        wd_o       = wd_q;
        wreg_o     = 1'b0;
        case (state)
            IDLE: begin
                stallreq_o = req_i;
                wdata_o    = alu_wdata_i;
                wd_o       = wd_i;
                wreg_o     = wreg_i;
            end
            RD, RLAST, WR: stallreq_o = 1'b1;
            DONE:          wreg_o     = wreg_q & ~we_q;
            default:       stallreq_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte RAM model, shadow-memory reference, random + directed accesses.
// Each access is checked for RAM addresses/data, stall length and writeback result.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_mem_access_ctrl;

    localparam int ADDR_W = 17;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              req_i;
    logic              we_i;
    logic [1:0]        size_i;
    logic              unsigned_i;
    logic [31:0]       addr_i;
    logic [31:0]       sdata_i;
    logic [31:0]       alu_wdata_i;
    logic [4:0]        wd_i;
    logic              wreg_i;
    logic [31:0]       wdata_o;
    logic [4:0]        wd_o;
    logic              wreg_o;
    logic              stallreq_o;
    logic [ADDR_W-1:0] mem_a_o;
    logic [7:0]        mem_dout_o;
    logic              mem_wr_o;
    logic [7:0]        mem_din_i;

    logic [7:0] ram    [0:DEPTH-1];
    logic [7:0] shadow [0:DEPTH-1];

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .sdata_i(sdata_i),
        .alu_wdata_i(alu_wdata_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o), .stallreq_o(stallreq_o),
        .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o),
        .mem_din_i(mem_din_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-wide synchronous single-port RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (mem_wr_o) ram[mem_a_o] <= mem_dout_o;
        mem_din_i <= ram[mem_a_o];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic scramble();
        we_i        = 1'($urandom);
        size_i      = 2'($urandom);
        unsigned_i  = 1'($urandom);
        addr_i      = $urandom;
        sdata_i     = $urandom;
        alu_wdata_i = $urandom;
        wd_i        = 5'($urandom);
        wreg_i      = 1'($urandom);
    endtask

    // One idle (non-memory) cycle: everything passes straight through, no stall, no write.
    task automatic idle_cycle(input logic [31:0] alu);
        @(posedge clk); #1;
        req_i       = 1'b0;
        alu_wdata_i = alu;
        wd_i        = 5'($urandom);
        wreg_i      = 1'($urandom);
        @(negedge clk);
        check("idle_stall", 32'(stallreq_o), 32'd0);
        check("idle_wdata", wdata_o, alu);
        check("idle_wd",    32'(wd_o),   32'(wd_i));
        check("idle_wreg",  32'(wreg_o), 32'(wreg_i));
        check("idle_wr",    32'(mem_wr_o), 32'd0);
    endtask

    // One memory access, held until DONE; leaves req_i high during DONE.
    task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] sd,
                           input logic [4:0] wd, input logic wreg);
        int n;
        int cyc;
        bit done;
        logic [ADDR_W-1:0] a0;
        logic [ADDR_W-1:0] ak;
        logic [31:0] exp_val;
        logic [31:0] b;
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        a0 = addr[ADDR_W-1:0];
        exp_val = 32'd0;
        if (!we) begin
            for (int k = 0; k < n; k++) begin
                ak = a0 + ADDR_W'(k);
                b  = 32'(shadow[ak]);
                exp_val = exp_val + b * (32'd1 << (8 * k));
            end
            if (!uns && n == 1 && exp_val >= 32'd128)   exp_val = exp_val - 32'd256;
            if (!uns && n == 2 && exp_val >= 32'd32768) exp_val = exp_val - 32'd65536;
        end
        @(posedge clk); #1;
        req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns;
        addr_i = addr; sdata_i = sd; wd_i = wd; wreg_i = wreg;
        alu_wdata_i = $urandom;
        cyc  = 0;
        done = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            if (stallreq_o) begin
                if (cyc >= 1 && cyc <= n) begin
                    ak = a0 + ADDR_W'(cyc - 1);
                    check("ram_addr", 32'(mem_a_o), 32'(ak));
                    check("ram_wr", 32'(mem_wr_o), 32'(we));
                    if (we) check("ram_wdat", 32'(mem_dout_o), (sd >> (8 * (cyc - 1))) & 32'hFF);
                end else begin
                    check("ram_wr_off", 32'(mem_wr_o), 32'd0);
                end
                cyc++;
                @(posedge clk); #1;
                scramble();
            end else begin
                done = 1;
            end
        end
        if (!done) check("timeout", 32'd0, 32'd1);
        check("stall_cycles", 32'(cyc), we ? 32'(n + 1) : 32'(n + 2));
        check("done_wdata", wdata_o, exp_val);
        check("done_wd",    32'(wd_o),   32'(wd));
        check("done_wreg",  32'(wreg_o), we ? 32'd0 : 32'(wreg));
        check("done_wr",    32'(mem_wr_o), 32'd0);
        if (we) begin
            for (int k = 0; k < n; k++) begin
                ak = a0 + ADDR_W'(k);
                shadow[ak] = 8'((sd >> (8 * k)) & 32'hFF);
            end
        end
    endtask

    initial begin
        logic [7:0] old12;
        logic [7:0] old13;
        logic [1:0] rs;
        logic [31:0] ra;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]    = 8'($urandom);
            shadow[i] = ram[i];
        end
        ram[17'h100] = 8'h78; ram[17'h101] = 8'h56; ram[17'h102] = 8'h34; ram[17'h103] = 8'h12;
        ram[17'h80]  = 8'h80;
        ram[17'h200] = 8'hFE; ram[17'h201] = 8'h7F;
        for (int i = 0; i < 4; i++) shadow[17'h100 + i] = ram[17'h100 + i];
        shadow[17'h80]  = ram[17'h80];
        shadow[17'h200] = ram[17'h200];
        shadow[17'h201] = ram[17'h201];

        rst = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0; unsigned_i = 1'b0;
        addr_i = 32'd0; sdata_i = 32'd0; alu_wdata_i = 32'hA5A5_0001; wd_i = 5'd3; wreg_i = 1'b1;

        // Reset state: registered RAM port at zero, IDLE outputs follow inputs.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mem_a",    32'(mem_a_o), 32'd0);
        check("rst_mem_dout", 32'(mem_dout_o), 32'd0);
        check("rst_mem_wr",   32'(mem_wr_o), 32'd0);
        check("rst_stall",    32'(stallreq_o), 32'd0);
        check("rst_wdata",    wdata_o, 32'hA5A5_0001);
        check("rst_wd",       32'(wd_o), 32'd3);
        req_i = 1'b1;
        #1;
        check("rst_stall_req", 32'(stallreq_o), 32'd1);
        @(posedge clk); #1;
        req_i = 1'b0;
        rst   = 1'b1;

        // Directed loads and a wrapping store.
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 5'd7, 1'b1);
        check("lw_value", wdata_o, 32'h1234_5678);
        run_txn(1'b0, 2'd0, 1'b0, 32'h0000_0080, 32'd0, 5'd8, 1'b1);
        check("lb_value", wdata_o, 32'hFFFF_FF80);
        run_txn(1'b0, 2'd0, 1'b1, 32'h0000_0080, 32'd0, 5'd9, 1'b1);
        check("lbu_value", wdata_o, 32'h0000_0080);
        run_txn(1'b0, 2'd1, 1'b0, 32'h0000_0200, 32'd0, 5'd10, 1'b1);
        check("lh_value", wdata_o, 32'h0000_7FFE);
        run_txn(1'b1, 2'd1, 1'b0, 32'h0001_FFFF, 32'h1234_ABCD, 5'd11, 1'b1);
        idle_cycle(32'h55);
        check("sh_wrap_lo", 32'(ram[17'h1FFFF]), 32'hCD);
        check("sh_wrap_hi", 32'(ram[17'h00000]), 32'hAB);

        // Store interrupted by reset after its second byte.
        old12 = shadow[17'h12];
        old13 = shadow[17'h13];
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b1; size_i = 2'd2; unsigned_i = 1'b0;
        addr_i = 32'h10; sdata_i = 32'hDEAD_BEEF; wd_i = 5'd1; wreg_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; req_i = 1'b0;
        @(negedge clk);
        check("rst_mid_wr",   32'(mem_wr_o), 32'd1);
        check("rst_mid_addr", 32'(mem_a_o), 32'h11);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_wr",    32'(mem_wr_o), 32'd0);
            check("post_rst_stall", 32'(stallreq_o), 32'd0);
            @(posedge clk); #1;
        end
        check("abort_b0", 32'(ram[17'h10]), 32'hEF);
        check("abort_b1", 32'(ram[17'h11]), 32'hBE);
        check("abort_b2", 32'(ram[17'h12]), 32'(old12));
        check("abort_b3", 32'(ram[17'h13]), 32'(old13));
        shadow[17'h10] = 8'hEF;
        shadow[17'h11] = 8'hBE;

        // Non-memory stream, then back-to-back LW and SB.
        idle_cycle(32'h55);
        idle_cycle(32'h55);
        run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5'd12, 1'b1);
        check("lw_after_rst", wdata_o, {old13, old12, 16'hBEEF});
        run_txn(1'b1, 2'd0, 1'b0, 32'h300, 32'h0000_00C3, 5'd13, 1'b1);
        idle_cycle(32'h55);

        // Random mix; accesses concentrated in a few regions so loads hit earlier stores.
        for (int t = 0; t < 300; t++) begin
            rs = 2'($urandom);
            ra = (rs == 2'd0) ? 32'h0001_FFF0 + ($urandom % 32) : ($urandom % 64) + ($urandom & 32'hFFFE_0000);
            if ($urandom_range(0, 3) == 0) idle_cycle($urandom);
            run_txn(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom, 5'($urandom), 1'($urandom));
        end
        idle_cycle($urandom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
